// File: rtl/audio_pkg.sv
// Shared types and constants for the PCM-to-PWM audio feeder.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int PCM_W     = 8;
  localparam int DUTY_W    = 16;
  localparam int PWM_FRAME = 513;

  // Doubling keeps full-scale at 510, always below the 0..512 PWM frame.
  function automatic logic [DUTY_W-1:0] to_duty(
    input logic [PCM_W-1:0] s
  );
    return {7'b0, s, 1'b0};
  endfunction

endpackage

// File: rtl/audio_pcm_feeder_if.sv
// Sample write port from the bus bridge plus FIFO status back to it.
interface audio_pcm_feeder_if #(
  parameter int DEPTH = 16
);
  import audio_pkg::*;

  logic                   wr_en;
  logic [PCM_W-1:0]       wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with flush and registered occupancy.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [PCM_W-1:0]       wr_data,
  input  logic                   rd,
  output logic [PCM_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PCM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_ok   = wr && !full && !flush;
  assign rd_ok   = rd && !empty && !flush;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      level <= level + LW'(wr_ok) - LW'(rd_ok);
    end
  end

endmodule

// File: rtl/audio_pcm_feeder.sv
// PCM sample FIFO + sample-rate divider feeding the PWM duty threshold.
// Optional low-water interrupt: define AUDIO_FEEDER_LOWWATER_EN.
module audio_pcm_feeder
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV  = PWM_FRAME,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4,
  parameter int LOW_WATER   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_flags,
  audio_pcm_feeder_if.slave bus,
  output logic              underrun,
  output logic              overflow,
  output logic [DUTY_W-1:0] duty,
  output logic              sample_tick
`ifdef AUDIO_FEEDER_LOWWATER_EN
  ,
  output logic              low_irq
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(SAMPLE_DIV);

  if (SAMPLE_DIV < 2 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      PRIME_LEVEL < 1 || PRIME_LEVEL > DEPTH ||
      LOW_WATER < 0 || LOW_WATER > DEPTH) begin : g_bad_cfg
    $error("audio_pcm_feeder: illegal parameter set");
  end

  state_t           state;
  state_t           state_nx;
  logic [DW-1:0]    div_cnt;
  logic [PCM_W-1:0] rd_data;
  logic             act;
  logic             tick;
  logic             pop;
  logic             starve;
  logic             ovf_set;

  // en low acts immediately: flush, zero duty, no pop, no flag events.
  assign act     = en && (state != IDLE);
  assign tick    = (state == RUN) && (div_cnt == DW'(SAMPLE_DIV - 1));
  assign pop     = act && tick && !bus.empty;
  assign starve  = act && tick && bus.empty;
  assign ovf_set = act && bus.wr_en && bus.full;

  audio_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (!act),
    .wr      (act && bus.wr_en),
    .wr_data (bus.wr_data),
    .rd      (pop),
    .rd_data (rd_data),
    .level   (bus.level),
    .full    (bus.full),
    .empty   (bus.empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = PRIME;
      PRIME:   if (bus.level >= LW'(PRIME_LEVEL)) state_nx = RUN;
      RUN:     if (starve) state_nx = PRIME;
      default: state_nx = IDLE;
    endcase
    if (!en) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)                             div_cnt <= '0;
    else if (state == RUN && en && !tick) div_cnt <= div_cnt + 1'b1;
    else                                 div_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty        <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sample_tick <= pop;
      if (!act)     duty <= '0;
      else if (pop) duty <= to_duty(rd_data);
      underrun <= starve  | (underrun & ~clr_flags);
      overflow <= ovf_set | (overflow & ~clr_flags);
    end
  end

`ifdef AUDIO_FEEDER_LOWWATER_EN
  always_ff @(posedge clk) begin
    if (rst) low_irq <= 1'b0;
    else     low_irq <= (state != IDLE) && (bus.level < LW'(LOW_WATER));
  end
`endif

endmodule

// File: tb/tb_audio_pcm_feeder.sv
// Directed bench for audio_pcm_feeder with an 8-clock sample period.
module tb_audio_pcm_feeder;
  import audio_pkg::*;

  localparam int DIV   = 8;
  localparam int DEPTH = 16;
  localparam int PL    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_flags = 1'b0;
  logic        underrun;
  logic        overflow;
  logic        sample_tick;
  logic [15:0] duty;
`ifdef AUDIO_FEEDER_LOWWATER_EN
  logic        low_irq;
`endif

  int vectors = 0;
  int errs = 0;

  audio_pcm_feeder_if #(.DEPTH(DEPTH)) bus ();

  audio_pcm_feeder #(
    .SAMPLE_DIV  (DIV),
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (PL),
    .LOW_WATER   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr_flags   (clr_flags),
    .bus         (bus),
    .underrun    (underrun),
    .overflow    (overflow),
    .duty        (duty),
    .sample_tick (sample_tick)
`ifdef AUDIO_FEEDER_LOWWATER_EN
    ,
    .low_irq     (low_irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int quiet;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // reset
    step();
    step();
    rst = 1'b0;
    chk("rst_duty", duty, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);

    // enabled but starved: stays in PRIME
    en = 1'b1;
    quiet = 0;
    repeat (50) begin
      step();
      quiet += int'(sample_tick);
    end
    chk("prime_no_tick", quiet, 0);
    chk("prime_duty", duty, 0);
    chk("prime_underrun", underrun, 0);

    // prime with four samples, then play them
    wr(8'h00);
    wr(8'h80);
    wr(8'hFF);
    wr(8'h01);
    chk("prime_level", bus.level, 4);
    wait_tick(n);
    chk("first_latency", n, 9);
    chk("duty_00", duty, 0);
    wait_tick(n);
    chk("period_1", n, 8);
    chk("duty_80", duty, 256);
    wait_tick(n);
    chk("period_2", n, 8);
    chk("duty_ff", duty, 510);
    wait_tick(n);
    chk("period_3", n, 8);
    chk("duty_01", duty, 2);
    quiet = 0;
    repeat (8) begin
      step();
      quiet += int'(sample_tick);
    end
    chk("underrun_no_tick", quiet, 0);
    chk("underrun_set", underrun, 1);
    chk("underrun_duty_hold", duty, 2);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("underrun_clr", underrun, 0);

    // fill to full and overflow; one pop lands mid-burst
    for (int i = 0; i < 19; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      clr_flags   = (i == 18);
      step();
      if (i == 12) begin
        chk("burst_pop_tick", sample_tick, 1);
        chk("burst_pop_oldest", duty, 32);
        chk("burst_pop_level", bus.level, 12);
      end
      if (i == 16) begin
        chk("full_flag", bus.full, 1);
        chk("full_level", bus.level, 16);
        chk("full_no_ovf", overflow, 0);
      end
      if (i == 17) begin
        chk("ovf_set", overflow, 1);
        chk("ovf_level", bus.level, 16);
      end
      if (i == 18) chk("ovf_set_beats_clr", overflow, 1);
    end
    bus.wr_en = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("ovf_clr_level", bus.level, 16);

    // drain to level 5, then write on the pop edge
    for (int k = 0; k < 11; k++) begin
      wait_tick(n);
      chk("drain_tick", sample_tick, 1);
    end
    chk("drain_level", bus.level, 5);
    chk("drain_duty", duty, 54);
    repeat (7) step();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hAA;
    step();
    bus.wr_en   = 1'b0;
    chk("wr_pop_tick", sample_tick, 1);
    chk("wr_pop_level", bus.level, 5);
    chk("wr_pop_oldest", duty, 56);

    // drain completely, underrun, then resume
    for (int k = 0; k < 5; k++) wait_tick(n);
    chk("last_duty", duty, 340);
    chk("drained_empty", bus.empty, 1);
    quiet = 0;
    repeat (8) begin
      step();
      quiet += int'(sample_tick);
    end
    chk("underrun2_no_tick", quiet, 0);
    chk("underrun2_set", underrun, 1);
    chk("underrun2_duty_hold", duty, 340);
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    wr(8'h04);
    wait_tick(n);
    chk("resume_latency", n, 9);
    chk("resume_duty", duty, 2);
    chk("resume_level", bus.level, 3);
    step();
`ifdef AUDIO_FEEDER_LOWWATER_EN
    chk("low_irq_run", low_irq, 1);
`endif

    // drop enable mid-period at level 6
    wr(8'h05);
    wr(8'h06);
    wr(8'h07);
    chk("pre_stop_level", bus.level, 6);
    step();
    en = 1'b0;
    step();
    chk("stop_duty", duty, 0);
    chk("stop_level", bus.level, 0);
    chk("stop_empty", bus.empty, 1);
    chk("stop_tick", sample_tick, 0);
    wr(8'h55);
    chk("idle_wr_level", bus.level, 0);
    chk("idle_wr_empty", bus.empty, 1);
`ifdef AUDIO_FEEDER_LOWWATER_EN
    chk("low_irq_idle", low_irq, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
